// File: rtl/ctrl_pkg.sv
`default_nettype none
// ctrl_pkg: shared encodings for the multicycle RV32I control FSM (ALU ops, states, opcodes, selects).
// rev 1.0
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SRL   = 4'b0011,
    ALU_SRA   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_XOR   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_BRANCH = 3'd4;
  localparam state_t S_MEM    = 3'd5;
  localparam state_t S_WB     = 3'd6;
  localparam state_t S_HALT   = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_ALUC   = 2'd2;

  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  // True when opcode/funct3/funct7 name a base RV32I instruction this core executes.
  function automatic logic instr_legal(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_OP:     ok = (f7 == 7'b0000000) ||
                       ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OPIMM:  ok = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                       (f3 == 3'b101) ? ((f7 == 7'b0000000) || (f7 == F7_ALT)) : 1'b1;
      OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  ok = (f3 <= 3'b010);
      OPC_BRANCH: ok = (f3[2:1] != 2'b01);
      OPC_JALR:   ok = (f3 == 3'b000);
      OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_op_decode.sv
`default_nettype none
// alu_op_decode: combinational opcode/funct3/funct7[5] -> ALU operation for EXEC and BRANCH.
// rev 1.0
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_opcode)
      OPC_OP, OPC_OPIMM: begin
        case (i_funct3)
          // OP-IMM has no SUBI, so funct7[5] only selects SUB for register ops
          3'b000:  o_alu_op = (i_opcode == OPC_OP && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_op = ALU_SLL;
          3'b010:  o_alu_op = ALU_SLT;
          3'b011:  o_alu_op = ALU_SLTU;
          3'b100:  o_alu_op = ALU_XOR;
          3'b101:  o_alu_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_op = ALU_OR;
          default: o_alu_op = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (i_funct3[2:1])
          2'b00:   o_alu_op = ALU_SUB;
          2'b10:   o_alu_op = ALU_SLT;
          2'b11:   o_alu_op = ALU_SLTU;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      OPC_LUI: o_alu_op = ALU_PASSB;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: fetch/decode/execute/memory/writeback control FSM for the multicycle RV32I core.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (undecodable instructions halt with a sticky flag). rev 1.0
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RESET_TO_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  localparam state_t RESET_STATE = (RESET_TO_FETCH != 0) ? S_FETCH : S_IDLE;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [3:0]  w_dec_op;
  logic        w_legal;
  logic        w_taken;
  logic        w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_legal  = instr_legal(w_opcode, w_funct3, w_funct7);
  assign w_unused = ^{instr[24:15], instr[11:7]};
  // funct3[2] flips the sense: EQ/NE taken on zero/!zero, LT/GE family on !zero/zero
  assign w_taken  = w_funct3[2] ? (alu_zero == w_funct3[0]) : (alu_zero != w_funct3[0]);

  alu_op_decode u_alu_op_decode (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7_5 (w_funct7[5]),
    .o_alu_op   (w_dec_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RESET_STATE;
    else        r_state <= w_next;
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_legal)   r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end else if (w_opcode == OPC_BRANCH) w_next = S_BRANCH;
        else if (w_opcode == OPC_JAL)        w_next = S_WB;
        else                                 w_next = S_EXEC;
      end
      S_EXEC:   w_next = (w_opcode == OPC_LOAD || w_opcode == OPC_STORE) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) w_next = (w_opcode == OPC_LOAD) ? S_WB : S_FETCH;
      S_WB,
      S_BRANCH: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = RESET_STATE;
    endcase
  end

  // Outputs are forced low while rst_n is asserted so reset silences the port immediately.
  always_comb begin
    ir_wr     = 1'b0;
    pc_wr     = 1'b0;
    pc_src    = 1'b0;
    alu_op    = ALU_ADD;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    imm_sel   = IMM_I;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALUOUT;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_a_sel = A_PC;
          alu_b_sel = B_FOUR;
          ir_wr     = mem_ready;
          pc_wr     = mem_ready;
        end
        S_DECODE: begin
          alu_a_sel = A_OLDPC;
          alu_b_sel = B_IMM;
          imm_sel   = (w_opcode == OPC_JAL) ? IMM_J : IMM_B;
        end
        S_EXEC: begin
          alu_op = w_dec_op;
          case (w_opcode)
            OPC_OP:    alu_b_sel = B_RS2;
            OPC_STORE: begin alu_b_sel = B_IMM; imm_sel = IMM_S; end
            OPC_LUI:   begin alu_b_sel = B_IMM; imm_sel = IMM_U; end
            OPC_AUIPC: begin alu_a_sel = A_OLDPC; alu_b_sel = B_IMM; imm_sel = IMM_U; end
            default:   begin alu_b_sel = B_IMM; imm_sel = IMM_I; end
          endcase
        end
        S_BRANCH: begin
          alu_op = w_dec_op;
          pc_wr  = w_taken;
          pc_src = w_taken;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (w_opcode == OPC_STORE);
        end
        S_WB: begin
          rf_we = 1'b1;
          case (w_opcode)
            OPC_LOAD: wb_sel = WB_MDR;
            // jumps: ALUOut already holds the target, ALU recomputes OldPC+4 for rd
            OPC_JAL, OPC_JALR: begin
              pc_wr     = 1'b1;
              pc_src    = 1'b1;
              wb_sel    = WB_ALUC;
              alu_a_sel = A_OLDPC;
              alu_b_sel = B_FOUR;
            end
            default: wb_sel = WB_ALUOUT;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: directed per-cycle checks of the multicycle control FSM outputs.
// rev 1.0
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, alu_zero, mem_ready;
  logic [31:0] instr;
  logic        ir_wr, pc_wr, pc_src, mem_req, mem_we, addr_sel, rf_we, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  alu_a_sel, alu_b_sel, wb_sel;
  logic [2:0]  imm_sel;
  logic [20:0] w_outs;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [20:0] e_fetch, e_fetchw, e_decb, e_decj, e_wb, e_wbld, e_wbj, e_memld, e_memst;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_TO_FETCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_op(alu_op),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm_sel(imm_sel), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal)
  );

  assign w_outs = {ir_wr, pc_wr, pc_src, alu_op, alu_a_sel, alu_b_sel, imm_sel,
                   mem_req, mem_we, addr_sel, rf_we, wb_sel, illegal};

  // Field order: ir_wr pc_wr pc_src alu_op a b imm mem_req mem_we addr_sel rf_we wb_sel illegal
  function automatic logic [20:0] v(input logic ir, input logic pcw, input logic pcs,
                                    input logic [3:0] op, input logic [1:0] a,
                                    input logic [1:0] b, input logic [2:0] imm,
                                    input logic req, input logic we, input logic as,
                                    input logic rf, input logic [1:0] wb, input logic ill);
    return {ir, pcw, pcs, op, a, b, imm, req, we, as, rf, wb, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a falling edge: drive inputs, sample outputs, then advance one cycle.
  task automatic cyc(input string tag, input logic rdy, input logic zero, input logic [20:0] exp);
    mem_ready = rdy;
    alu_zero  = zero;
    #1;
    chk(tag, {11'd0, w_outs}, {11'd0, exp});
    @(negedge clk);
  endtask

  task automatic alu_instr(input string tag, input logic [31:0] ins, input logic [20:0] exp_exec);
    instr = ins;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, e_fetch);
    cyc({tag, "_decode"}, 1'b1, 1'b0, e_decb);
    cyc({tag, "_exec"}, 1'b1, 1'b0, exp_exec);
    cyc({tag, "_wb"}, 1'b1, 1'b0, e_wb);
  endtask

  task automatic branch(input string tag, input logic [31:0] ins, input logic zero,
                        input logic [20:0] exp_br);
    instr = ins;
    cyc({tag, "_fetch"}, 1'b1, 1'b0, e_fetch);
    cyc({tag, "_decode"}, 1'b1, 1'b0, e_decb);
    cyc({tag, "_branch"}, 1'b1, zero, exp_br);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0; instr = 32'h0;
    e_fetch  = v(1, 1, 0, 4'h0, 2'd1, 2'd2, 3'd0, 1, 0, 0, 0, 2'd0, 0);
    e_fetchw = v(0, 0, 0, 4'h0, 2'd1, 2'd2, 3'd0, 1, 0, 0, 0, 2'd0, 0);
    e_decb   = v(0, 0, 0, 4'h0, 2'd2, 2'd1, 3'd2, 0, 0, 0, 0, 2'd0, 0);
    e_decj   = v(0, 0, 0, 4'h0, 2'd2, 2'd1, 3'd4, 0, 0, 0, 0, 2'd0, 0);
    e_wb     = v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 1, 2'd0, 0);
    e_wbld   = v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 1, 2'd1, 0);
    e_wbj    = v(0, 1, 1, 4'h0, 2'd2, 2'd2, 3'd0, 0, 0, 0, 1, 2'd2, 0);
    e_memld  = v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 1, 0, 1, 0, 2'd0, 0);
    e_memst  = v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 1, 1, 1, 0, 2'd0, 0);

    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", {11'd0, w_outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU class: add, sub, srai, sltiu, lui, auipc
    alu_instr("add",   32'h002081B3, v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    alu_instr("sub",   32'h402081B3, v(0, 0, 0, 4'h1, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    alu_instr("srai",  32'h4050D193, v(0, 0, 0, 4'h4, 2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    alu_instr("sltiu", 32'h0070B193, v(0, 0, 0, 4'h6, 2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    alu_instr("lui",   32'h123451B7, v(0, 0, 0, 4'hA, 2'd0, 2'd1, 3'd3, 0, 0, 0, 0, 2'd0, 0));
    alu_instr("auipc", 32'h00001197, v(0, 0, 0, 4'h0, 2'd2, 2'd1, 3'd3, 0, 0, 0, 0, 2'd0, 0));

    // lw with 3 fetch wait cycles and 2 memory wait cycles: 10 cycles total
    instr = 32'h0040A183;
    for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", 1'b0, 1'b0, e_fetchw);
    cyc("lw_fetch", 1'b1, 1'b0, e_fetch);
    cyc("lw_decode", 1'b1, 1'b0, e_decb);
    cyc("lw_exec", 1'b0, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    for (int i = 0; i < 2; i++) cyc("lw_mem_wait", 1'b0, 1'b0, e_memld);
    cyc("lw_mem_ready", 1'b1, 1'b0, e_memld);
    cyc("lw_wb", 1'b0, 1'b0, e_wbld);
    cyc("lw_next_fetch", 1'b0, 1'b0, e_fetchw);

    // sw: FETCH, DECODE, EXEC, MEM then straight back to FETCH
    instr = 32'h0020A423;
    cyc("sw_fetch", 1'b1, 1'b0, e_fetch);
    cyc("sw_decode", 1'b1, 1'b0, e_decb);
    cyc("sw_exec", 1'b1, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd1, 3'd1, 0, 0, 0, 0, 2'd0, 0));
    cyc("sw_mem", 1'b1, 1'b0, e_memst);
    cyc("sw_next_fetch", 1'b0, 1'b0, e_fetchw);

    // Branches: taken/not-taken sense per funct3
    branch("bne_taken",  32'h00209463, 1'b0, v(0, 1, 1, 4'h1, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    branch("bne_not",    32'h00209463, 1'b1, v(0, 0, 0, 4'h1, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    branch("bltu_not",   32'h0020E463, 1'b1, v(0, 0, 0, 4'h6, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    branch("bge_taken",  32'h0020D463, 1'b1, v(0, 1, 1, 4'h5, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    cyc("br_next_fetch", 1'b0, 1'b0, e_fetchw);

    // jal: 3 cycles; jalr: 4 cycles
    instr = 32'h010000EF;
    cyc("jal_fetch", 1'b1, 1'b0, e_fetch);
    cyc("jal_decode", 1'b1, 1'b0, e_decj);
    cyc("jal_wb", 1'b1, 1'b0, e_wbj);
    instr = 32'h000100E7;
    cyc("jalr_fetch", 1'b1, 1'b0, e_fetch);
    cyc("jalr_decode", 1'b1, 1'b0, e_decb);
    cyc("jalr_exec", 1'b1, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    cyc("jalr_wb", 1'b1, 1'b0, e_wbj);

    // Asynchronous reset while waiting in MEM
    instr = 32'h0040A183;
    cyc("rst_lw_fetch", 1'b1, 1'b0, e_fetch);
    cyc("rst_lw_decode", 1'b1, 1'b0, e_decb);
    cyc("rst_lw_exec", 1'b0, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd1, 3'd0, 0, 0, 0, 0, 2'd0, 0));
    cyc("rst_lw_mem_wait", 1'b0, 1'b0, e_memld);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs", {11'd0, w_outs}, 32'd0);
    @(negedge clk);
    #1 chk("rst_held_outputs", {11'd0, w_outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_release_fetch", 1'b0, 1'b0, e_fetchw);

    // Undecodable instructions
`ifndef MC_ILLEGAL_TRAP_EN
    instr = 32'h022081B3;
    cyc("badf7_fetch", 1'b1, 1'b0, e_fetch);
    cyc("badf7_decode", 1'b1, 1'b0, e_decb);
    cyc("badf7_nop_fetch", 1'b0, 1'b0, e_fetchw);
`endif
    instr = 32'h0000007F;
    cyc("ill_fetch", 1'b1, 1'b0, e_fetch);
    cyc("ill_decode", 1'b1, 1'b0, e_decb);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("ill_halt", 1'b1, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 1));
    cyc("ill_halt_hold", 1'b1, 1'b0, v(0, 0, 0, 4'h0, 2'd0, 2'd0, 3'd0, 0, 0, 0, 0, 2'd0, 1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("ill_cleared_fetch", 1'b0, 1'b0, e_fetchw);
`else
    cyc("ill_nop_fetch", 1'b0, 1'b0, e_fetchw);
    cyc("ill_nop_fetch_hold", 1'b0, 1'b0, e_fetchw);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
